// File: rtl/ram_access_ctrl_if.sv
// Bus bundle between a request/response initiator and the RAM pins it drives.
// The controller takes the slave view; a sequencer/RAM pair takes the master view.
interface ram_access_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_datain;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_dataout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dataout,
    output req_ready, rsp_valid, rsp_data, rsp_we, ram_addr, ram_datain, ram_read, ram_write
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dataout,
    input  req_ready, rsp_valid, rsp_data, rsp_we, ram_addr, ram_datain, ram_read, ram_write
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Single-outstanding RAM initiator: sequences setup, strobe and recovery phases on the RAM
// pins for each accepted request, then holds a registered response until it is taken.
module ram_access_ctrl #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 4,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int RECOVERY_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_access_ctrl_if.slave bus
);

  localparam int MAX_SR  = (SETUP_CYC > RECOVERY_CYC) ? SETUP_CYC : RECOVERY_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_SR) ? STROBE_CYC : MAX_SR;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RECOVER,
    S_RESP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_phase_done;
  logic              w_accept;

  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0] r_ram_datain, w_ram_datain_nxt;
  logic              r_ram_read, w_ram_read_nxt;
  logic              r_ram_write, w_ram_write_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_we, w_rsp_we_nxt;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_phase_done = 1'b0;
    case (r_state)
      S_SETUP:   w_phase_done = (r_cnt == CNT_W'(SETUP_CYC - 1));
      S_STROBE:  w_phase_done = (r_cnt == CNT_W'(STROBE_CYC - 1));
      S_RECOVER: w_phase_done = (r_cnt == CNT_W'(RECOVERY_CYC - 1));
      default:   w_phase_done = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode; the phase counter restarts at zero on every phase change
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      S_SETUP, S_STROBE, S_RECOVER: begin
        if (w_phase_done) begin
          w_cnt_nxt = '0;
          case (r_state)
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_RECOVER;
            default:  w_state_nxt = S_RESP;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, so the registered pins change on the phase edge
  always_comb begin
    w_we_nxt         = w_accept ? bus.req_we    : r_we;
    w_ram_addr_nxt   = w_accept ? bus.req_addr  : r_ram_addr;
    w_ram_datain_nxt = w_accept ? bus.req_wdata : r_ram_datain;
    w_rsp_we_nxt     = w_accept ? bus.req_we    : r_rsp_we;
    w_ram_write_nxt  = (w_state_nxt == S_STROBE) &&  w_we_nxt;
    w_ram_read_nxt   = (w_state_nxt == S_STROBE) && !w_we_nxt;
    w_rsp_valid_nxt  = (w_state_nxt == S_RESP);
    w_rsp_data_nxt   = r_rsp_data;
    if (w_accept) begin
      w_rsp_data_nxt = '0;
    end else if ((r_state == S_STROBE) && w_phase_done && !r_we) begin
      w_rsp_data_nxt = bus.ram_dataout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_datain <= '0;
      r_ram_read   <= 1'b0;
      r_ram_write  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_we     <= 1'b0;
    end else begin
      r_we         <= w_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_datain <= w_ram_datain_nxt;
      r_ram_read   <= w_ram_read_nxt;
      r_ram_write  <= w_ram_write_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_we     <= w_rsp_we_nxt;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_we     = r_rsp_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_datain = r_ram_datain;
  assign bus.ram_read   = r_ram_read;
  assign bus.ram_write  = r_ram_write;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: a default-timing instance and a slow-timing instance, each with a
// behavioural RAM, checked against an expected-memory array and phase lengths derived from the parameters.
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_we    = 1'b0;
  logic [3:0] req_addr  = 4'h0;
  logic [3:0] req_wdata = 4'h0;
  logic       rsp_ready = 1'b0;
  bit         sel       = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int overlap     = 0;

  logic [3:0] ref_mem [2][16];
  logic [3:0] exp_rsp_data;
  logic       exp_rsp_we;
  logic [3:0] cur_addr;
  logic [3:0] cur_wdata;

  ram_access_ctrl_if #(.DATA_W(4), .ADDR_W(4)) if_a ();
  ram_access_ctrl_if #(.DATA_W(4), .ADDR_W(4)) if_b ();

  ram_access_ctrl #(.DATA_W(4), .ADDR_W(4)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  ram_access_ctrl #(.DATA_W(4), .ADDR_W(4), .SETUP_CYC(2), .STROBE_CYC(3), .RECOVERY_CYC(2))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.req_valid = req_valid && !sel;
  assign if_b.req_valid = req_valid && sel;
  assign if_a.rsp_ready = rsp_ready && !sel;
  assign if_b.rsp_ready = rsp_ready && sel;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;

  // Behavioural RAMs: write on an edge with the write strobe high, read data driven only while read is high
  logic [3:0] mem_a [16];
  logic [3:0] mem_b [16];
  always @(posedge clk) begin
    if (if_a.ram_write) mem_a[if_a.ram_addr] <= if_a.ram_datain;
    if (if_b.ram_write) mem_b[if_b.ram_addr] <= if_b.ram_datain;
    if (if_a.ram_read && if_a.ram_write) overlap <= overlap + 1;
    if (if_b.ram_read && if_b.ram_write) overlap <= overlap + 1;
  end
  assign if_a.ram_dataout = if_a.ram_read ? mem_a[if_a.ram_addr] : 4'h0;
  assign if_b.ram_dataout = if_b.ram_read ? mem_b[if_b.ram_addr] : 4'h0;

  wire       m_req_ready  = sel ? if_b.req_ready  : if_a.req_ready;
  wire       m_rsp_valid  = sel ? if_b.rsp_valid  : if_a.rsp_valid;
  wire [3:0] m_rsp_data   = sel ? if_b.rsp_data   : if_a.rsp_data;
  wire       m_rsp_we     = sel ? if_b.rsp_we     : if_a.rsp_we;
  wire [3:0] m_ram_addr   = sel ? if_b.ram_addr   : if_a.ram_addr;
  wire [3:0] m_ram_datain = sel ? if_b.ram_datain : if_a.ram_datain;
  wire       m_ram_read   = sel ? if_b.ram_read   : if_a.ram_read;
  wire       m_ram_write  = sel ? if_b.ram_write  : if_a.ram_write;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and return at the negedge where rsp_valid is first seen
  task automatic issue(input bit we, input logic [3:0] addr, input logic [3:0] wdata);
    int k, good_strobe, bad_strobe, hold_err;
    int exp_lat, exp_strobe;
    exp_lat    = sel ? 2 + 3 + 2 : 1 + 2 + 1;
    exp_strobe = sel ? 3 : 2;
    check("req_ready_before_issue", m_req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    cur_addr  = addr;
    cur_wdata = wdata;
    if (we) ref_mem[sel][addr] = wdata;
    exp_rsp_data = we ? 4'h0 : ref_mem[sel][addr];
    exp_rsp_we   = we;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 4'($urandom);
    req_wdata = 4'($urandom);
    k = 0; good_strobe = 0; bad_strobe = 0; hold_err = 0;
    while (!m_rsp_valid && k < 40) begin
      if (m_ram_addr !== addr || m_ram_datain !== wdata || m_req_ready !== 1'b0) hold_err++;
      if (we ? m_ram_write : m_ram_read) good_strobe++;
      if (we ? m_ram_read : m_ram_write) bad_strobe++;
      @(negedge clk);
      k++;
    end
    check("latency_edges", k, exp_lat);
    check("strobe_cycles", good_strobe, exp_strobe);
    check("wrong_strobe_cycles", bad_strobe, 0);
    check("addr_data_hold", hold_err, 0);
  endtask

  task automatic take_rsp();
    check("rsp_valid", m_rsp_valid, 1);
    check("rsp_data", m_rsp_data, exp_rsp_data);
    check("rsp_we", m_rsp_we, exp_rsp_we);
    check("addr_held_in_resp", m_ram_addr, cur_addr);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", m_rsp_valid, 0);
    check("req_ready_after_resp", m_req_ready, 1);
    check("addr_kept_in_idle", m_ram_addr, cur_addr);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    logic [3:0] held;
    logic [3:0] a;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready_a", if_a.req_ready, 1);
    check("rst_rsp_valid_a", if_a.rsp_valid, 0);
    check("rst_rsp_data_a", if_a.rsp_data, 0);
    check("rst_rsp_we_a", if_a.rsp_we, 0);
    check("rst_ram_addr_a", if_a.ram_addr, 0);
    check("rst_ram_datain_a", if_a.ram_datain, 0);
    check("rst_strobes_a", {if_a.ram_read, if_a.ram_write}, 0);
    check("rst_req_ready_b", if_b.req_ready, 1);
    check("rst_outputs_b", {if_b.rsp_valid, if_b.ram_read, if_b.ram_write, if_b.ram_addr}, 0);

    // Write then read back, with phase timing checked inside issue()
    issue(1'b1, 4'h3, 4'hA);
    take_rsp();
    issue(1'b0, 4'h3, 4'h5);
    take_rsp();

    // Backpressure: response held for 5 cycles, a request pulse in the meantime is ignored
    issue(1'b0, 4'h3, 4'h0);
    held = m_rsp_data;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_addr  = 4'h5;
      req_wdata = 4'h7;
      @(negedge clk);
      check("bp_rsp_valid", m_rsp_valid, 1);
      check("bp_rsp_data_stable", m_rsp_data, held);
      check("bp_req_ready", m_req_ready, 0);
    end
    req_valid = 1'b0;
    take_rsp();
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_ram_read || m_ram_write || !m_req_ready) k++;
    end
    check("bp_pulse_not_accepted", k, 0);

    // Reset during a read strobe aborts the access
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'h3;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!m_ram_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_strobe", m_ram_read, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_strobes_low", {m_ram_read, m_ram_write}, 0);
    check("abort_rsp_valid", m_rsp_valid, 0);
    check("abort_req_ready", m_req_ready, 1);
    check("abort_addr_cleared", m_ram_addr, 0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_rsp_valid) k++;
    end
    check("abort_no_response", k, 0);
    issue(1'b0, 4'h3, 4'h1);
    take_rsp();
    check("after_abort_read", exp_rsp_data, 4'hA);

    // All 16 addresses: write addr^0xF, read all back
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      issue(1'b1, a, a ^ 4'hF);
      take_rsp();
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      issue(1'b0, a, 4'($urandom));
      check("sweep_model", exp_rsp_data, a ^ 4'hF);
      take_rsp();
    end

    // Random mix with random response delay
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom), 4'($urandom), 4'($urandom));
      k = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++) @(negedge clk);
      take_rsp();
    end

    // Slow-timing instance
    sel = 1'b1;
    issue(1'b1, 4'h7, 4'h5);
    take_rsp();
    issue(1'b0, 4'h7, 4'h0);
    take_rsp();
    issue(1'b1, 4'hC, 4'h9);
    take_rsp();
    issue(1'b0, 4'hC, 4'h2);
    take_rsp();
    sel = 1'b0;

    @(negedge clk);
    check("strobe_overlap_cycles", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
